// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module : dmem_responder
// Word-organised data memory answering M-stage load/store requests after a
//          fixed number of wait states, with misalignment reporting.
// Rev    : 1.0
// ============================================================================
module dmem_responder #(
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [3:0]  req_w_en,
  input  logic [2:0]  req_f3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         C_DEPTH     = 1 << (ADDR_W - 2);
  localparam logic [3:0] C_WCNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_wcnt;
  logic [3:0]        w_wcnt_nxt;

  logic [3:0]        r_w_en;
  logic [1:0]        r_f3;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;

  logic [31:0]       r_mem [C_DEPTH];

  logic              w_accept;
  logic              w_enter_resp;
  logic [3:0]        w_w_en;
  logic [1:0]        w_f3;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_wdata;
  logic [1:0]        w_off;
  logic [ADDR_W-3:0] w_idx;
  logic              w_is_store;
  logic [1:0]        w_size;
  logic              w_misaligned;
  logic [7:0]        w_lane_wide;
  logic [3:0]        w_lane;
  logic [31:0]       w_wdata_sh;
  logic [31:0]       w_rshift;
  logic [31:0]       w_load;
  logic              w_wr_en;
  logic              w_unused_ok;

  assign w_unused_ok = ^{req_f3[2], req_addr[31:ADDR_W]};

  assign busy     = req_valid && (r_state != ST_RESP) && !rst;
  assign w_accept = (r_state == ST_IDLE) && req_valid;

  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES > 0) begin
            w_state_nxt = ST_WAIT;
            w_wcnt_nxt  = C_WCNT_INIT;
          end else begin
            w_state_nxt = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (r_wcnt == 4'd0) begin
          w_state_nxt = ST_RESP;
        end else begin
          w_wcnt_nxt = r_wcnt - 4'd1;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_wcnt  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
    end
  end

  assign w_enter_resp = (w_state_nxt == ST_RESP);

  // With zero wait states the access happens on the accept edge, so the live
  // request is used in IDLE and the captured copy everywhere else.
  assign w_w_en  = (r_state == ST_IDLE) ? req_w_en             : r_w_en;
  assign w_f3    = (r_state == ST_IDLE) ? req_f3[1:0]          : r_f3;
  assign w_addr  = (r_state == ST_IDLE) ? req_addr[ADDR_W-1:0] : r_addr;
  assign w_wdata = (r_state == ST_IDLE) ? req_wdata            : r_wdata;

  assign w_off      = w_addr[1:0];
  assign w_idx      = w_addr[ADDR_W-1:2];
  assign w_is_store = |w_w_en;

  always_comb begin
    w_size = 2'd2;
    if (w_is_store) begin
      w_size = w_w_en[3] ? 2'd2 : (w_w_en[1] ? 2'd1 : 2'd0);
    end else if (w_f3 == 2'b00) begin
      w_size = 2'd0;
    end else if (w_f3 == 2'b01) begin
      w_size = 2'd1;
    end
  end

  assign w_misaligned = ((w_size == 2'd1) && w_off[0]) ||
                        ((w_size == 2'd2) && (w_off != 2'd0));

  assign w_lane_wide = {4'b0000, w_w_en} << w_off;
  assign w_lane      = w_lane_wide[3:0];
  assign w_wdata_sh  = w_wdata << {w_off, 3'b000};
  assign w_rshift    = r_mem[w_idx] >> {w_off, 3'b000};

  always_comb begin
    w_load = w_rshift;
    case (w_size)
      2'd0:    w_load = {24'd0, w_rshift[7:0]};
      2'd1:    w_load = {16'd0, w_rshift[15:0]};
      default: w_load = w_rshift;
    endcase
  end

  assign w_wr_en = w_enter_resp && w_is_store && !w_misaligned && !rst;

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (w_lane[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_w_en    <= 4'd0;
      r_f3      <= 2'd0;
      r_addr    <= '0;
      r_wdata   <= 32'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_w_en  <= req_w_en;
        r_f3    <= req_f3[1:0];
        r_addr  <= req_addr[ADDR_W-1:0];
        r_wdata <= req_wdata;
      end
      rsp_valid <= w_enter_resp;
      rsp_err   <= w_enter_resp && w_misaligned;
      rsp_rdata <= (w_enter_resp && !w_is_store && !w_misaligned) ? w_load : 32'd0;
    end
  end

endmodule
`default_nettype wire
